camera_capture_roi: RTL and testbench
=====================================

Name: camera_capture_roi

Overview:
- Parametrised successor to the single-shot raw capture block.
- Captures raw sensor pixels inside a configurable region of interest (ROI) and emits them with ROI-relative X/Y coordinates.
- Supports single-shot and continuous (free-running) modes, and flags frames that end before the ROI is complete.
- Sits between the sensor pins and the downstream pixel pipeline (Bayer/position logic).

Parameters:
- DATA_W, 12, sensor pixel width in bits.
- CNT_W, 12, width of coordinate and size fields.

Ports:
- clock  in  1  system/pixel clock.
- reset  in  1  asynchronous, active-high reset.
- in_roi_x  in  CNT_W  ROI first sensor column.
- in_roi_y  in  CNT_W  ROI first sensor row.
- in_roi_width  in  CNT_W  ROI columns; 0 is treated as 1.
- in_roi_height  in  CNT_W  ROI rows; 0 is treated as 1.
- in_continuous  in  1  1 = re-arm after each frame.
- in_start  in  1  start request, level or pulse.
- in_stop  in  1  return to IDLE at the next frame boundary.
- in_line_valid  in  1  sensor LVAL.
- in_frame_valid  in  1  sensor FVAL.
- in_data  in  DATA_W  sensor pixel.
- out_valid  out  1  ROI pixel strobe.
- out_data  out  DATA_W  ROI pixel.
- out_count_x  out  CNT_W  ROI-relative column.
- out_count_y  out  CNT_W  ROI-relative row.
- out_frame_done  out  1  1-cycle pulse after the last ROI pixel.
- out_captured  out  1  high in IDLE or DONE.
- out_error  out  1  sticky: frame ended early.

Behaviour:
- Reset (asynchronous, active-high): all outputs 0 except out_captured = 1. State = IDLE, counters = 0, config registers = 0.
- Configuration: all in_roi_* and in_continuous are latched on the cycle in_start is accepted in IDLE/DONE. They are ignored at all other times.
- Input stage: in_line_valid, in_frame_valid and in_data are registered once. Edge detection uses the registered copies.
- Latency: in_data to out_data is exactly 2 clocks. out_count_x/y are aligned with out_data.
- Sensor counters:
  - col: increments on each registered pixel with LVAL & FVAL; cleared on LVAL falling edge.
  - row: increments on LVAL falling edge; cleared on FVAL rising edge.
  - Both saturate at 2^CNT_W-1.
- ROI end arithmetic: x_end = roi_x + width and y_end = roi_y + height, computed in CNT_W+1 bits. ROIs extending past the sensor never complete and end in error.
- ROI hit condition: col >= roi_x && col < x_end && row >= roi_y && row < y_end. Output coordinates are col - roi_x and row - roi_y.
- FSM states:
  - IDLE: in_start goes to ARM.
  - ARM: wait for FVAL rising edge, then go to CAPTURE. A frame already in progress at start is skipped.
  - CAPTURE:
    - Last ROI pixel (x = width-1, y = height-1) emitted: out_frame_done pulse, then DONE (single mode) or ARM (continuous mode).
    - FVAL falls before the last ROI pixel: out_error set, then DONE (single mode) or ARM (continuous mode).
  - DONE: behaves as IDLE; in_start re-arms.
- out_captured = 1 in IDLE and DONE, 0 in ARM and CAPTURE.
- out_error: cleared when in_start is accepted. In continuous mode it stays set until stop/start.
- in_stop: in ARM, go to IDLE immediately. In CAPTURE, finish the current frame, then go to DONE regardless of mode. in_stop takes priority over in_start on the same cycle.
- in_start while in ARM or CAPTURE: ignored.
- FVAL rising while in CAPTURE without a prior fall (glitch): treat as an early end, then re-enter CAPTURE for the new frame.
- Reset mid-frame: immediate return to IDLE; the pipeline is flushed and out_valid drops asynchronously.

Optional Feature:
- Macro: CAPTURE_DECIMATE_EN.
- With the macro defined:
  - Extra inputs in_skip_x and in_skip_y (4 bits each, latched with config).
  - An ROI pixel is emitted only when the relative x mod (skip_x+1) == 0 and the relative y mod (skip_y+1) == 0.
  - out_count_x/y report the decimated index.
  - Completion still occurs on the last ROI pixel position, even if that pixel itself is not emitted.
- Without the macro: no skip ports; every ROI pixel is emitted.

Decomposition:
- Package camera_capture_pkg:
  - FSM state enum (IDLE, ARM, CAPTURE, DONE).
  - Default CNT_W/DATA_W constants.
  - Skip field width constant.
- Sub-module: sensor_pos_counter. Contains the registered input stage, edge detect, and col/row counters, and outputs col, row, pix_valid, frame_rise, frame_fall. The ROI compare and FSM stay in the top.

Test Plan:
1. Full-frame capture: sensor 8x4, ROI (0,0,8,4), single mode, pulse start → 32 out_valid, coordinates (0,0)..(7,3), out_frame_done once, then out_captured = 1, out_error = 0.
2. ROI window: ROI (2,1,3,2) on an 8x4 frame with data = row*16+col → outputs 0x12,0x13,0x14,0x22,0x23,0x24 with coordinates (0,0)..(2,1); each out_data appears 2 clocks after its in_data.
3. Early end: ROI (0,0,8,4), FVAL drops after row 2 → out_error = 1, no frame_done, DONE; the next start clears out_error.
4. Mid-frame start and continuous mode: start asserted during a frame, continuous = 1, three frames run → the first partial frame is skipped, out_frame_done pulses three times, then in_stop gives one more full frame and then out_captured = 1.
5. Asynchronous reset asserted mid-CAPTURE → out_valid = 0 and out_captured = 1 immediately (no clock needed); no output after release until a new start.
6. With CAPTURE_DECIMATE_EN: skip_x = 1, skip_y = 1, ROI 8x4 → 8 pixels emitted at sensor (0,0),(2,0),(4,0),(6,0),(0,2),(2,2),(4,2),(6,2), coordinates (0..3, 0..1), out_frame_done after sensor pixel (7,3).

Source files
------------

// File: rtl/camera_capture_pkg.sv
// Shared types and constants for the ROI camera capture block.
// Optional decimation is enabled by defining CAPTURE_DECIMATE_EN.
package camera_capture_pkg;

   localparam int DEF_DATA_W = 12;
   localparam int DEF_CNT_W  = 12;
   localparam int SKIP_W     = 4;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ARM     = 2'd1,
      ST_CAPTURE = 2'd2,
      ST_DONE    = 2'd3
   } cap_state_e;

endpackage

// File: rtl/camera_capture_roi_sensor_pos_counter.sv
// Sensor-side front end: registers LVAL/FVAL/data once, detects edges on the
// registered copies and tracks the sensor column/row of each registered pixel.
module sensor_pos_counter
   import camera_capture_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int CNT_W  = DEF_CNT_W
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              in_line_valid,
   input  logic              in_frame_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              pix_valid,
   output logic [DATA_W-1:0] pix_data,
   output logic [CNT_W-1:0]  col,
   output logic [CNT_W-1:0]  row,
   output logic              frame_rise,
   output logic              frame_fall
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic              lval_q, lval_d, fval_q, fval_d;
   logic              lval_p_q, lval_p_d, fval_p_q, fval_p_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [CNT_W-1:0]  col_q, col_d, row_q, row_d;
   logic              line_fall;

   // Input stage, edge detection and saturating position counters.
   always_comb begin
      lval_d     = in_line_valid;
      fval_d     = in_frame_valid;
      data_d     = in_data;
      lval_p_d   = lval_q;
      fval_p_d   = fval_q;
      line_fall  = lval_p_q & ~lval_q;
      frame_rise = fval_q & ~fval_p_q;
      frame_fall = fval_p_q & ~fval_q;
      pix_valid  = lval_q & fval_q;
      col_d = col_q;
      if (line_fall)
         col_d = '0;
      else if (pix_valid && col_q != CNT_MAX)
         col_d = col_q + CNT_W'(1);
      row_d = row_q;
      if (frame_rise)
         row_d = '0;
      else if (line_fall && row_q != CNT_MAX)
         row_d = row_q + CNT_W'(1);
      // A pixel arriving together with the frame rise belongs to row 0.
      pix_data = data_q;
      col      = col_q;
      row      = frame_rise ? '0 : row_q;
   end

   // Register stage for the sensor front end.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         lval_q   <= 1'b0;
         fval_q   <= 1'b0;
         lval_p_q <= 1'b0;
         fval_p_q <= 1'b0;
         data_q   <= '0;
         col_q    <= '0;
         row_q    <= '0;
      end else begin
         lval_q   <= lval_d;
         fval_q   <= fval_d;
         lval_p_q <= lval_p_d;
         fval_p_q <= fval_p_d;
         data_q   <= data_d;
         col_q    <= col_d;
         row_q    <= row_d;
      end
   end

endmodule

// File: rtl/camera_capture_roi.sv
// ROI camera capture: single-shot / continuous capture of a sensor window with
// ROI-relative coordinates, frame-done pulse and sticky early-end error.
// Define CAPTURE_DECIMATE_EN to add in_skip_x/in_skip_y pixel decimation.
module camera_capture_roi
   import camera_capture_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int CNT_W  = DEF_CNT_W
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [CNT_W-1:0]  in_roi_x,
   input  logic [CNT_W-1:0]  in_roi_y,
   input  logic [CNT_W-1:0]  in_roi_width,
   input  logic [CNT_W-1:0]  in_roi_height,
   input  logic              in_continuous,
   input  logic              in_start,
   input  logic              in_stop,
`ifdef CAPTURE_DECIMATE_EN
   input  logic [SKIP_W-1:0] in_skip_x,
   input  logic [SKIP_W-1:0] in_skip_y,
`endif
   input  logic              in_line_valid,
   input  logic              in_frame_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   output logic [CNT_W-1:0]  out_count_x,
   output logic [CNT_W-1:0]  out_count_y,
   output logic              out_frame_done,
   output logic              out_captured,
   output logic              out_error
);

   logic              pix_valid, frame_rise, frame_fall;
   logic [DATA_W-1:0] pix_data;
   logic [CNT_W-1:0]  col, row;

   sensor_pos_counter #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_pos (
      .clock          (clock),
      .reset          (reset),
      .in_line_valid  (in_line_valid),
      .in_frame_valid (in_frame_valid),
      .in_data        (in_data),
      .pix_valid      (pix_valid),
      .pix_data       (pix_data),
      .col            (col),
      .row            (row),
      .frame_rise     (frame_rise),
      .frame_fall     (frame_fall)
   );

   cap_state_e        state_q, state_d, end_state;
   logic [CNT_W-1:0]  roi_x_q, roi_x_d, roi_y_q, roi_y_d;
   logic [CNT_W-1:0]  roi_w_q, roi_w_d, roi_h_q, roi_h_d;
   logic              cont_q, cont_d, stop_pend_q, stop_pend_d;
   logic              valid_q, valid_d, done_q, done_d;
   logic              captured_q, captured_d, error_q, error_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [CNT_W-1:0]  cnt_x_q, cnt_x_d, cnt_y_q, cnt_y_d;
`ifdef CAPTURE_DECIMATE_EN
   logic [SKIP_W-1:0] skip_x_q, skip_x_d, skip_y_q, skip_y_d;
   logic [CNT_W-1:0]  div_x, div_y;
`endif

   logic [CNT_W:0]    x_end, y_end;
   logic [CNT_W-1:0]  rel_x, rel_y, dec_x, dec_y;
   logic              hit, last, emit;

   // ROI window compare; ends carry an extra bit so oversize ROIs never wrap.
   always_comb begin
      x_end = {1'b0, roi_x_q} + {1'b0, roi_w_q};
      y_end = {1'b0, roi_y_q} + {1'b0, roi_h_q};
      rel_x = col - roi_x_q;
      rel_y = row - roi_y_q;
      hit   = (col >= roi_x_q) && ({1'b0, col} < x_end) &&
              (row >= roi_y_q) && ({1'b0, row} < y_end);
      last  = hit && (rel_x == roi_w_q - CNT_W'(1)) && (rel_y == roi_h_q - CNT_W'(1));
`ifdef CAPTURE_DECIMATE_EN
      div_x = CNT_W'(skip_x_q) + CNT_W'(1);
      div_y = CNT_W'(skip_y_q) + CNT_W'(1);
      emit  = hit && ((rel_x % div_x) == '0) && ((rel_y % div_y) == '0);
      dec_x = rel_x / div_x;
      dec_y = rel_y / div_y;
`else
      emit  = hit;
      dec_x = rel_x;
      dec_y = rel_y;
`endif
   end

   // Capture FSM next state, config latch and output stage.
   always_comb begin
      state_d     = state_q;
      roi_x_d     = roi_x_q;
      roi_y_d     = roi_y_q;
      roi_w_d     = roi_w_q;
      roi_h_d     = roi_h_q;
      cont_d      = cont_q;
      stop_pend_d = stop_pend_q;
      error_d     = error_q;
      data_d      = data_q;
      cnt_x_d     = cnt_x_q;
      cnt_y_d     = cnt_y_q;
      valid_d     = 1'b0;
      done_d      = 1'b0;
`ifdef CAPTURE_DECIMATE_EN
      skip_x_d    = skip_x_q;
      skip_y_d    = skip_y_q;
`endif
      // A pending or current stop forces DONE even in continuous mode.
      end_state = (stop_pend_q || in_stop || !cont_q) ? ST_DONE : ST_ARM;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (in_start && !in_stop) begin
               roi_x_d = in_roi_x;
               roi_y_d = in_roi_y;
               roi_w_d = (in_roi_width  == '0) ? CNT_W'(1) : in_roi_width;
               roi_h_d = (in_roi_height == '0) ? CNT_W'(1) : in_roi_height;
               cont_d  = in_continuous;
`ifdef CAPTURE_DECIMATE_EN
               skip_x_d = in_skip_x;
               skip_y_d = in_skip_y;
`endif
               error_d = 1'b0;
               state_d = ST_ARM;
            end
         end
         ST_ARM: begin
            if (in_stop)
               state_d = ST_IDLE;
            else if (frame_rise)
               state_d = ST_CAPTURE;
         end
         ST_CAPTURE: begin
            if (in_stop)
               stop_pend_d = 1'b1;
            if (pix_valid && emit) begin
               valid_d = 1'b1;
               data_d  = pix_data;
               cnt_x_d = dec_x;
               cnt_y_d = dec_y;
            end
            if (pix_valid && last) begin
               done_d  = 1'b1;
               state_d = end_state;
            end else if (frame_fall) begin
               error_d = 1'b1;
               state_d = end_state;
            end else if (frame_rise) begin
               // New frame without a fall: early end, and the new frame is
               // already under way so a re-arm goes straight back to CAPTURE.
               error_d = 1'b1;
               state_d = (end_state == ST_ARM) ? ST_CAPTURE : ST_DONE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (state_d != ST_CAPTURE)
         stop_pend_d = 1'b0;
      captured_d = (state_d == ST_IDLE) || (state_d == ST_DONE);
   end

   // State and output registers; reset flushes the output stage at once.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         roi_x_q     <= '0;
         roi_y_q     <= '0;
         roi_w_q     <= '0;
         roi_h_q     <= '0;
         cont_q      <= 1'b0;
         stop_pend_q <= 1'b0;
         error_q     <= 1'b0;
         data_q      <= '0;
         cnt_x_q     <= '0;
         cnt_y_q     <= '0;
         valid_q     <= 1'b0;
         done_q      <= 1'b0;
         captured_q  <= 1'b1;
`ifdef CAPTURE_DECIMATE_EN
         skip_x_q    <= '0;
         skip_y_q    <= '0;
`endif
      end else begin
         state_q     <= state_d;
         roi_x_q     <= roi_x_d;
         roi_y_q     <= roi_y_d;
         roi_w_q     <= roi_w_d;
         roi_h_q     <= roi_h_d;
         cont_q      <= cont_d;
         stop_pend_q <= stop_pend_d;
         error_q     <= error_d;
         data_q      <= data_d;
         cnt_x_q     <= cnt_x_d;
         cnt_y_q     <= cnt_y_d;
         valid_q     <= valid_d;
         done_q      <= done_d;
         captured_q  <= captured_d;
`ifdef CAPTURE_DECIMATE_EN
         skip_x_q    <= skip_x_d;
         skip_y_q    <= skip_y_d;
`endif
      end
   end

   assign out_valid      = valid_q;
   assign out_data       = data_q;
   assign out_count_x    = cnt_x_q;
   assign out_count_y    = cnt_y_q;
   assign out_frame_done = done_q;
   assign out_captured   = captured_q;
   assign out_error      = error_q;

endmodule

// File: tb/tb_camera_capture_roi.sv
// Self-checking bench for camera_capture_roi: randomized pixel data and ROIs
// compared against a window/queue reference model of the capture rules.
module tb_camera_capture_roi;

   localparam int DW = 12;
   localparam int CW = 12;

   logic          clock = 1'b0;
   logic          reset;
   logic [CW-1:0] in_roi_x, in_roi_y, in_roi_width, in_roi_height;
   logic          in_continuous, in_start, in_stop;
   logic          in_line_valid, in_frame_valid;
   logic [DW-1:0] in_data;
   logic          out_valid, out_frame_done, out_captured, out_error;
   logic [DW-1:0] out_data;
   logic [CW-1:0] out_count_x, out_count_y;
`ifdef CAPTURE_DECIMATE_EN
   logic [3:0]    in_skip_x, in_skip_y;
`endif

   camera_capture_roi #(.DATA_W(DW), .CNT_W(CW)) dut (
      .clock          (clock),
      .reset          (reset),
      .in_roi_x       (in_roi_x),
      .in_roi_y       (in_roi_y),
      .in_roi_width   (in_roi_width),
      .in_roi_height  (in_roi_height),
      .in_continuous  (in_continuous),
      .in_start       (in_start),
      .in_stop        (in_stop),
`ifdef CAPTURE_DECIMATE_EN
      .in_skip_x      (in_skip_x),
      .in_skip_y      (in_skip_y),
`endif
      .in_line_valid  (in_line_valid),
      .in_frame_valid (in_frame_valid),
      .in_data        (in_data),
      .out_valid      (out_valid),
      .out_data       (out_data),
      .out_count_x    (out_count_x),
      .out_count_y    (out_count_y),
      .out_frame_done (out_frame_done),
      .out_captured   (out_captured),
      .out_error      (out_error)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   int nchk = 0, nerr = 0, done_cnt = 0, exp_done = 0, n_px = 0;
   // expected pixel: {data, x, y, cycle it must appear in}
   logic [55:0] exp_q[$];
   int  rx, ry, rw, rh, sx = 0, sy = 0;
   bit  data_pat = 1'b0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nchk++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic set_cfg(input int x, input int y, input int w, input int h, input bit c);
      in_roi_x = CW'(x); in_roi_y = CW'(y);
      in_roi_width = CW'(w); in_roi_height = CW'(h);
      in_continuous = c;
      rx = x; ry = y;
      rw = (w == 0) ? 1 : w;
      rh = (h == 0) ? 1 : h;
`ifdef CAPTURE_DECIMATE_EN
      in_skip_x = 4'(sx); in_skip_y = 4'(sy);
`endif
   endtask

   task automatic start_pulse();
      in_start = 1'b1; step(); in_start = 1'b0; step();
   endtask

   task automatic stop_pulse();
      in_stop = 1'b1; step(); in_stop = 1'b0; step();
   endtask

   // Reference rule: a pixel in the ROI window on the decimation grid is
   // emitted with ROI-relative (decimated) coordinates two cycles later.
   function automatic void expect_px(input int c, input int r, input logic [DW-1:0] d);
      if (c >= rx && c < rx + rw && r >= ry && r < ry + rh &&
          ((c - rx) % (sx + 1)) == 0 && ((r - ry) % (sy + 1)) == 0)
         exp_q.push_back({d, 12'((c - rx) / (sx + 1)), 12'((r - ry) / (sy + 1)), 20'(cyc + 2)});
   endfunction

   task automatic frame(input int w, input int rows, input bit cap, input int start_row, input int stop_row);
      logic [DW-1:0] d;
      in_frame_valid = 1'b1;
      step(); step();
      for (int r = 0; r < rows; r++) begin
         if (r == start_row) in_start = 1'b1;
         if (r == stop_row)  in_stop  = 1'b1;
         for (int c = 0; c < w; c++) begin
            d = data_pat ? DW'(r * 16 + c) : DW'($urandom);
            in_line_valid = 1'b1;
            in_data = d;
            if (cap) expect_px(c, r, d);
            step();
            in_start = 1'b0;
            in_stop  = 1'b0;
         end
         in_line_valid = 1'b0;
         repeat ($urandom_range(1, 3)) step();
      end
      in_frame_valid = 1'b0;
      repeat (4) step();
      if (cap && rx + rw <= w && ry + rh <= rows) exp_done++;
   endtask

   // Output monitor: every strobe must match the head of the expected queue.
   always @(negedge clock) begin
      logic [55:0] e;
      if (out_frame_done) done_cnt++;
      if (out_valid) begin
         n_px++;
         if (exp_q.size() == 0) chk("extra_px", 64'(out_data), 64'hFFFF_FFFF_FFFF_FFFF);
         else begin
            e = exp_q.pop_front();
            chk("px", 64'({out_data, out_count_x, out_count_y, 20'(cyc)}), 64'(e));
         end
      end
   end

   initial begin
      logic [DW-1:0] d;
      int x0, y0, w0, h0;
      bit fits;
      reset = 1'b1;
      in_start = 0; in_stop = 0; in_line_valid = 0; in_frame_valid = 0; in_data = '0;
      set_cfg(0, 0, 8, 4, 0);
      step(); step();
      chk("rst_valid", 64'(out_valid), 64'd0);
      chk("rst_captured", 64'(out_captured), 64'd1);
      chk("rst_error", 64'(out_error), 64'd0);
      chk("rst_done", 64'(out_frame_done), 64'd0);
      chk("rst_data", 64'({out_data, out_count_x, out_count_y}), 64'd0);
      reset = 1'b0;
      step();

      // full frame single shot
      start_pulse();
      chk("arm_captured", 64'(out_captured), 64'd0);
      frame(8, 4, 1'b1, -1, -1);
      chk("t1_npx", 64'(n_px), 64'd32);
      chk("t1_done", 64'(done_cnt), 64'(exp_done));
      chk("t1_captured", 64'(out_captured), 64'd1);
      chk("t1_error", 64'(out_error), 64'd0);
      frame(8, 4, 1'b0, -1, -1);
      chk("t1_idle_done", 64'(done_cnt), 64'(exp_done));

      // ROI window with position-coded data
      data_pat = 1'b1;
      set_cfg(2, 1, 3, 2, 0);
      start_pulse();
      frame(8, 4, 1'b1, -1, -1);
      chk("t2_drain", 64'(exp_q.size()), 64'd0);
      chk("t2_npx", 64'(n_px), 64'd38);
      chk("t2_done", 64'(done_cnt), 64'(exp_done));
      data_pat = 1'b0;

      // early frame end
      set_cfg(0, 0, 8, 4, 0);
      start_pulse();
      frame(8, 3, 1'b1, -1, -1);
      chk("t3_error", 64'(out_error), 64'd1);
      chk("t3_done", 64'(done_cnt), 64'(exp_done));
      chk("t3_captured", 64'(out_captured), 64'd1);
      start_pulse();
      chk("t3_err_clr", 64'(out_error), 64'd0);
      stop_pulse();
      chk("t3_stop_arm", 64'(out_captured), 64'd1);

      // mid-frame start, continuous, then stop
      y0 = $urandom_range(0, 3);
      x0 = $urandom_range(0, 6);
      set_cfg(x0, y0, $urandom_range(1, 8 - x0), 4 - y0, 1);
      frame(8, 4, 1'b0, 1, -1);
      repeat (3) frame(8, 4, 1'b1, -1, -1);
      chk("t4_done3", 64'(done_cnt), 64'(exp_done));
      chk("t4_armed", 64'(out_captured), 64'd0);
      frame(8, 4, 1'b1, -1, 1);
      chk("t4_done4", 64'(done_cnt), 64'(exp_done));
      chk("t4_captured", 64'(out_captured), 64'd1);
      frame(8, 4, 1'b0, -1, -1);
      chk("t4_drain", 64'(exp_q.size()), 64'd0);

      // asynchronous reset mid-capture
      set_cfg(0, 0, 8, 4, 0);
      start_pulse();
      in_frame_valid = 1'b1;
      step(); step();
      for (int c = 0; c < 6; c++) begin
         d = DW'($urandom);
         in_line_valid = 1'b1;
         in_data = d;
         expect_px(c, 0, d);
         step();
      end
      chk("t5_pre_valid", 64'(out_valid), 64'd1);
      #2 reset = 1'b1;
      #1;
      chk("t5_valid", 64'(out_valid), 64'd0);
      chk("t5_captured", 64'(out_captured), 64'd1);
      in_line_valid = 1'b0; in_frame_valid = 1'b0;
      exp_q.delete();
      step(); step();
      reset = 1'b0;
      step();
      frame(8, 4, 1'b0, -1, -1);
      chk("t5_after", 64'(out_captured), 64'd1);

      // random ROIs, including zero sizes and windows past the sensor
      for (int i = 0; i < 5; i++) begin
         x0 = $urandom_range(0, 9); y0 = $urandom_range(0, 5);
         w0 = $urandom_range(0, 5); h0 = $urandom_range(0, 3);
         set_cfg(x0, y0, w0, h0, 0);
         fits = (rx + rw <= 8) && (ry + rh <= 4);
         start_pulse();
         frame(8, 4, 1'b1, -1, -1);
         chk("rnd_error", 64'(out_error), 64'(!fits));
         chk("rnd_done", 64'(done_cnt), 64'(exp_done));
         chk("rnd_drain", 64'(exp_q.size()), 64'd0);
      end

`ifdef CAPTURE_DECIMATE_EN
      sx = 1; sy = 1;
      set_cfg(0, 0, 8, 4, 0);
      x0 = n_px;
      start_pulse();
      frame(8, 4, 1'b1, -1, -1);
      chk("dec_npx", 64'(n_px - x0), 64'd8);
      chk("dec_done", 64'(done_cnt), 64'(exp_done));
      chk("dec_error", 64'(out_error), 64'd0);
`endif

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
